glitcbus_slave_v3: RTL
======================

GLITCBUS_SLAVE_V3 -- requirements
Module: glitcbus_slave_v3

Interface
REQ-001 SHALL have parameter ADDR_BYTES, default 2, number of address bytes per transaction (legal 1..4).
REQ-002 SHALL have parameter DATA_BYTES, default 4, number of data bytes per transaction (legal 1..8).
REQ-003 SHALL have parameter RD_LAT, default 2, cycles allowed for read data acknowledge (legal 1..15).
REQ-004 SHALL have port gclk_i, input, 1 bit, the single clock; all logic rising-edge.
REQ-005 SHALL have port grst_b_i, input, 1 bit, asynchronous active-low reset.
REQ-006 SHALL have port GAD, inout, 8 bits, multiplexed address/data bus.
REQ-007 SHALL have ports GSEL_B and GRDWR_B, input, 1 bit each; GSEL_B is active-low select and GRDWR_B is 1=read, 0=write.
REQ-008 SHALL have port gb_adr_o, output, 8*ADDR_BYTES bits, register address.
REQ-009 SHALL have port gb_dat_o, output, 8*DATA_BYTES bits, write data.
REQ-010 SHALL have port gb_dat_i, input, 8*DATA_BYTES bits, read data.
REQ-011 SHALL have port gb_ack_i, input, 1 bit, read data valid from register side.
REQ-012 SHALL have ports gwr_o and grd_o, output, 1 bit each, single-cycle write and read strobes.
REQ-013 SHALL have port busy_o, output, 1 bit, high when not IDLE.
REQ-014 SHALL have port err_cnt_o, output, 8 bits, saturating read-timeout count; err_clr_i, input, 1 bit, clears it.

Function
REQ-015 SHALL register GAD, GSEL_B and GRDWR_B in IOB flops (gad_q, gsel_b_q, grdwr_b_q); all decisions use the registered copies.
REQ-016 SHALL implement states IDLE, ADDR, WDATA, RWAIT, RDATA and TURN, with a byte counter of width clog2(max(ADDR_BYTES,DATA_BYTES)+1).
REQ-017 IDLE: on gsel_b_q=0, SHALL capture gad_q as the address MSB and latch grdwr_b_q as direction.
REQ-018 From IDLE, SHALL go to ADDR if ADDR_BYTES>1, else go directly to the direction's next state.
REQ-019 ADDR: SHALL capture the remaining ADDR_BYTES-1 bytes MSB-first, one per cycle, then go to WDATA (write) or RWAIT (read).
REQ-020 WDATA: SHALL capture DATA_BYTES bytes MSB-first into gb_dat_o, then return to IDLE.
REQ-021 SHALL pulse gwr_o for one cycle, the cycle after the last data byte is captured.
REQ-022 SHALL hold gb_adr_o and gb_dat_o stable while gwr_o is high.
REQ-023 SHALL pulse grd_o for one cycle on entry to RWAIT, with the full address valid on gb_adr_o.
REQ-024 RWAIT: SHALL last exactly RD_LAT cycles starting with the grd_o cycle.
REQ-025 RWAIT: SHALL latch gb_dat_i on the first cycle gb_ack_i=1; later acks in the window SHALL be ignored.
REQ-026 No ack in the RWAIT window: SHALL return all-ones read data and increment err_cnt_o, saturating at 255.
REQ-027 RDATA: SHALL drive DATA_BYTES bytes MSB-first, one per cycle, through IOB output flops.
REQ-028 SHALL make the output enable active exactly during RDATA; pins lag the state by one cycle.
REQ-029 After RDATA, SHALL spend one TURN cycle with GAD tri-stated, then return to IDLE.
REQ-030 gsel_b_q=1 in any non-IDLE state SHALL abort: return to IDLE next cycle, suppress any pending gwr_o/grd_o, and release the output enable.
REQ-031 An abort SHALL leave err_cnt_o unchanged.
REQ-032 If err_clr_i and a timeout coincide, err_cnt_o SHALL become 0 (clear wins).
REQ-033 The cycle after IDLE is re-entered, SHALL accept back-to-back transactions if gsel_b_q=0.

Reset
REQ-034 grst_b_i=0 SHALL asynchronously force state IDLE and all outputs to 0.
REQ-035 grst_b_i=0 SHALL force the output enable inactive (GAD high-Z) and clear the counters.
REQ-036 Reset asserted mid-transaction SHALL abort with no strobe; operation resumes on the first edge after release.

Verification
REQ-037 Write, defaults: addr bytes 12,34 then data AA,BB,CC,DD -> one gwr_o pulse with gb_adr_o=0x1234, gb_dat_o=0xAABBCCDD.
REQ-038 Read, gb_ack_i one cycle after grd_o with gb_dat_i=0x01020304 -> GAD bytes 01,02,03,04, then high-Z TURN.
REQ-039 Read, no ack -> GAD bytes FF,FF,FF,FF and err_cnt_o increments 0->1; 256 timeouts -> err_cnt_o=255.
REQ-040 GSEL_B deasserted after the 2nd write data byte -> no gwr_o; next full write completes normally.
REQ-041 ADDR_BYTES=1, DATA_BYTES=2: write 5A then 12,34 -> gb_adr_o=0x5A, gb_dat_o=0x1234.
REQ-042 grst_b_i pulsed low during RDATA -> GAD high-Z immediately, busy_o=0, err_cnt_o=0.

Source files
------------

// File: rtl/glitcbus_slave_v3.sv
// GLITCBUS slave: multiplexed 8-bit address/data bus to a parallel register port.
// Address and data travel MSB-first; read data comes back after a bounded wait.
module glitcbus_slave_v3 #(
  parameter int ADDR_BYTES = 2,
  parameter int DATA_BYTES = 4,
  parameter int RD_LAT     = 2
) (
  input  logic                    gclk_i,
  input  logic                    grst_b_i,
  inout  wire  [7:0]              GAD,
  input  logic                    GSEL_B,
  input  logic                    GRDWR_B,
  output logic [8*ADDR_BYTES-1:0] gb_adr_o,
  output logic [8*DATA_BYTES-1:0] gb_dat_o,
  input  logic [8*DATA_BYTES-1:0] gb_dat_i,
  input  logic                    gb_ack_i,
  output logic                    gwr_o,
  output logic                    grd_o,
  output logic                    busy_o,
  output logic [7:0]              err_cnt_o,
  input  logic                    err_clr_i
);

  localparam int AW   = 8 * ADDR_BYTES;
  localparam int DW   = 8 * DATA_BYTES;
  localparam int MAXB = (ADDR_BYTES > DATA_BYTES) ? ADDR_BYTES : DATA_BYTES;
  localparam int CW   = $clog2(MAXB + 1);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WDATA,
    RWAIT,
    RDATA,
    TURN
  } state_t;

  state_t state;
  state_t nxt;

  logic [7:0]    gad_q;
  logic          gsel_b_q;
  logic          grdwr_b_q;
  logic [7:0]    out_q;
  logic          oe_q;
  logic          dir;
  logic          got;
  logic [CW-1:0] cnt;
  logic [3:0]    wcnt;
  logic [DW-1:0] rbuf;

  logic          abort;
  logic          adr_last;
  logic          dat_last;
  logic          wait_last;
  logic          rd_entry;
  logic          timeout;
  logic [AW+7:0] adr_cat;
  logic [DW+7:0] dat_cat;
  logic [DW+7:0] rbuf_cat;

  assign GAD    = oe_q ? out_q : 8'hzz;
  assign busy_o = (state != IDLE);

  assign abort     = (state != IDLE) && gsel_b_q;
  assign adr_last  = (cnt == CW'(ADDR_BYTES - 1));
  assign dat_last  = (cnt == CW'(DATA_BYTES - 1));
  assign wait_last = (wcnt == 4'(RD_LAT - 1));
  assign rd_entry  = (nxt == RWAIT) && (state != RWAIT);
  assign timeout   = (state == RWAIT) && wait_last && !abort
                   && !got && !gb_ack_i;

  assign adr_cat  = {gb_adr_o, gad_q};
  assign dat_cat  = {gb_dat_o, gad_q};
  assign rbuf_cat = {rbuf, 8'h00};

  always_ff @(posedge gclk_i or negedge grst_b_i) begin
    if (!grst_b_i) begin
      gad_q     <= '0;
      gsel_b_q  <= 1'b1;
      grdwr_b_q <= 1'b0;
    end else begin
      gad_q     <= GAD;
      gsel_b_q  <= GSEL_B;
      grdwr_b_q <= GRDWR_B;
    end
  end

  always_ff @(posedge gclk_i or negedge grst_b_i) begin
    if (!grst_b_i) state <= IDLE;
    else           state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (!gsel_b_q) begin
          if (ADDR_BYTES > 1) nxt = ADDR;
          else if (grdwr_b_q) nxt = RWAIT;
          else                nxt = WDATA;
        end
      end
      ADDR:  if (adr_last)  nxt = dir ? RWAIT : WDATA;
      WDATA: if (dat_last)  nxt = IDLE;
      RWAIT: if (wait_last) nxt = RDATA;
      RDATA: if (dat_last)  nxt = TURN;
      TURN:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
    if (abort) nxt = IDLE;
  end

  always_ff @(posedge gclk_i or negedge grst_b_i) begin
    if (!grst_b_i) begin
      gb_adr_o <= '0;
      gb_dat_o <= '0;
      gwr_o    <= 1'b0;
      grd_o    <= 1'b0;
      out_q    <= '0;
      oe_q     <= 1'b0;
      dir      <= 1'b0;
      got      <= 1'b0;
      cnt      <= '0;
      wcnt     <= '0;
      rbuf     <= '0;
    end else begin
      gwr_o <= (state == WDATA) && dat_last && !abort;
      grd_o <= rd_entry;
      // Pins follow the RDATA state one cycle late through the IOB flops.
      oe_q  <= (state == RDATA) && !abort;
      case (state)
        IDLE: begin
          if (!gsel_b_q) begin
            gb_adr_o <= adr_cat[AW-1:0];
            dir      <= grdwr_b_q;
            cnt      <= (ADDR_BYTES > 1) ? CW'(1) : '0;
          end
        end
        ADDR: begin
          if (!abort) begin
            gb_adr_o <= adr_cat[AW-1:0];
            cnt      <= adr_last ? '0 : cnt + CW'(1);
          end
        end
        WDATA: begin
          if (!abort) begin
            gb_dat_o <= dat_cat[DW-1:0];
            cnt      <= dat_last ? '0 : cnt + CW'(1);
          end
        end
        RWAIT: begin
          if (!abort) begin
            wcnt <= wcnt + 4'd1;
            if (gb_ack_i && !got) begin
              rbuf <= gb_dat_i;
              got  <= 1'b1;
            end else if (timeout) begin
              rbuf <= '1;
            end
          end
        end
        RDATA: begin
          if (!abort) begin
            out_q <= rbuf[DW-1 -: 8];
            rbuf  <= rbuf_cat[DW-1:0];
            cnt   <= dat_last ? '0 : cnt + CW'(1);
          end
        end
        default: ;
      endcase
      if (abort) cnt <= '0;
      if (rd_entry) begin
        wcnt <= '0;
        got  <= 1'b0;
      end
    end
  end

  always_ff @(posedge gclk_i or negedge grst_b_i) begin
    if (!grst_b_i)                     err_cnt_o <= '0;
    else if (err_clr_i)                err_cnt_o <= '0;
    else if (timeout && err_cnt_o != 8'hff) err_cnt_o <= err_cnt_o + 8'd1;
  end

endmodule
